// File: rtl/spi_reg_target.sv
// spi_reg_target: SPI target; a command byte selects a register, then each
// data byte writes config or reads config/status. Optional: SPI_AUTO_INC_EN.
// Ports: clk/rstb/ena, mode {cpol,cpha}, spi_cs_n/spi_clk/spi_mosi (synced),
// spi_miso, config_regs (flat bank out), status_regs (flat bank in).
// Macro SPI_AUTO_INC_EN: defined = addr increments per data byte (burst),
// undefined = addr fixed for the whole transaction.
module spi_reg_target #(
  parameter int NUM_CFG   = 16,
  parameter int REG_WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rstb,
  input  logic                         ena,
  input  logic [1:0]                   mode,
  input  logic                         spi_cs_n,
  input  logic                         spi_clk,
  input  logic                         spi_mosi,
  output logic                         spi_miso,
  output logic [NUM_CFG*REG_WIDTH-1:0] config_regs,
  input  logic [NUM_CFG*REG_WIDTH-1:0] status_regs
);

  localparam int AW = $clog2(NUM_CFG);
  localparam int W  = REG_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_t;

  state_t        r_state;
  logic          r_sclk_q;
  logic          r_csn_q;
  logic [1:0]    r_mode;
  logic [2:0]    r_bit_cnt;
  logic [AW-1:0] r_addr;
  logic          r_rw;
  logic          r_bank;
  logic [W-2:0]  r_rx;
  logic [W-1:0]  r_tx;
  logic          r_miso;
  logic [W-1:0]  r_cfg [NUM_CFG];

  logic [W-1:0]  w_stat [NUM_CFG];
  logic          w_rise;
  logic          w_fall;
  logic          w_samp;
  logic          w_shift;
  logic [W-1:0]  w_byte;
  logic [AW-1:0] w_cmd_addr;
  logic          w_cmd_bank;
  logic [W-1:0]  w_cmd_tx;
  logic [AW-1:0] w_nxt_addr;
  logic [W-1:0]  w_nxt_tx;

  for (genvar i = 0; i < NUM_CFG; i++) begin : g_bank
    assign config_regs[i*W +: W] = r_cfg[i];
    assign w_stat[i] = status_regs[i*W +: W];
  end

  assign w_rise  = spi_clk & ~r_sclk_q;
  assign w_fall  = ~spi_clk & r_sclk_q;
  // cpol==cpha samples on the rising edge, otherwise on the falling edge
  assign w_samp  = (r_mode[1] == r_mode[0]) ? w_rise : w_fall;
  assign w_shift = (r_mode[1] == r_mode[0]) ? w_fall : w_rise;

  assign w_byte     = {r_rx, spi_mosi};
  // upper address bits beyond the bank size are ignored
  assign w_cmd_addr = AW'(w_byte[5:0]);
  // writes always echo the config bank
  assign w_cmd_bank = ~w_byte[7] & w_byte[6];
  assign w_cmd_tx   = w_cmd_bank ? w_stat[w_cmd_addr]
                                 : r_cfg[w_cmd_addr];

`ifdef SPI_AUTO_INC_EN
  assign w_nxt_addr = r_addr + AW'(1);
`else
  assign w_nxt_addr = r_addr;
`endif

  assign w_nxt_tx = r_bank ? w_stat[w_nxt_addr]
                           : r_cfg[w_nxt_addr];

  // cpha=0 drives the tx MSB directly; cpha=1 uses the shift-edge register
  assign spi_miso = (r_state == IDLE) ? 1'b0
                  : (r_mode[0] ? r_miso : r_tx[W-1]);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= IDLE;
      r_sclk_q  <= 1'b0;
      // reset as "low" so a cs_n already low must return high first
      r_csn_q   <= 1'b0;
      r_mode    <= 2'b00;
      r_bit_cnt <= 3'd0;
      r_addr    <= '0;
      r_rw      <= 1'b0;
      r_bank    <= 1'b0;
      r_rx      <= '0;
      r_tx      <= '0;
      r_miso    <= 1'b0;
      for (int i = 0; i < NUM_CFG; i++) begin
        r_cfg[i] <= '0;
      end
    end else if (ena) begin
      r_sclk_q <= spi_clk;
      r_csn_q  <= spi_cs_n;
      if (spi_cs_n) begin
        r_state   <= IDLE;
        r_bit_cnt <= 3'd0;
        r_addr    <= '0;
        r_rx      <= '0;
        r_tx      <= '0;
        r_miso    <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (r_csn_q) begin
              r_state <= CMD;
              r_mode  <= mode;
            end
          end
          CMD, DATA: begin
            if (w_samp) begin
              r_rx      <= w_byte[W-2:0];
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (r_state == CMD) begin
                  r_state <= DATA;
                  r_rw    <= w_byte[7];
                  r_bank  <= w_cmd_bank;
                  r_addr  <= w_cmd_addr;
                  r_tx    <= w_cmd_tx;
                end else begin
                  if (r_rw) begin
                    r_cfg[r_addr] <= w_byte;
                  end
                  r_addr <= w_nxt_addr;
                  r_tx   <= w_nxt_tx;
                end
              end
            end else if (w_shift) begin
              if (r_mode[0]) begin
                r_miso <= r_tx[W-1];
                r_tx   <= r_tx << 1;
              end else if (r_bit_cnt != 3'd0) begin
                // hold the freshly loaded MSB across the byte boundary
                r_tx <= r_tx << 1;
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_reg_target.sv
// tb_spi_reg_target: scoreboard bench for spi_reg_target.
// Directed SPI transactions in all four modes, abort and reset cases.
module tb_spi_reg_target;

  localparam int N  = 16;
  localparam int BW = N * 8;

`ifdef SPI_AUTO_INC_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic          clk      = 1'b0;
  logic          rstb     = 1'b0;
  logic          ena      = 1'b1;
  logic [1:0]    mode     = 2'b00;
  logic          spi_cs_n = 1'b1;
  logic          spi_clk  = 1'b0;
  logic          spi_mosi = 1'b0;
  logic          spi_miso;
  logic [BW-1:0] config_regs;
  logic [BW-1:0] status_regs;

  typedef struct {
    string         nm;
    logic [BW-1:0] v;
  } exp_t;

  exp_t          exp_q[$];
  logic [BW-1:0] act_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [7:0]    m_cfg [N];
  logic          cur_cpha = 1'b0;
  logic [7:0]    junk;
  exp_t          mon_x;
  logic [BW-1:0] mon_a;

  spi_reg_target #(
    .NUM_CFG  (N),
    .REG_WIDTH(8)
  ) dut (
    .clk        (clk),
    .rstb       (rstb),
    .ena        (ena),
    .mode       (mode),
    .spi_cs_n   (spi_cs_n),
    .spi_clk    (spi_clk),
    .spi_mosi   (spi_mosi),
    .spi_miso   (spi_miso),
    .config_regs(config_regs),
    .status_regs(status_regs)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1, "watchdog");
  end

  // monitor: pops one expected entry per presented actual
  initial begin
    forever begin
      @(negedge clk);
      while (act_q.size() > 0) begin
        mon_a = act_q.pop_front();
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard: actual %h has no expected entry",
                   mon_a);
        end else begin
          mon_x = exp_q.pop_front();
          checks++;
          if (mon_a !== mon_x.v) begin
            errors++;
            $display("FAIL %s: got %h required %h",
                     mon_x.nm, mon_a, mon_x.v);
          end
        end
      end
    end
  end

  task automatic half();
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_v(input string nm,
                          input logic [BW-1:0] e,
                          input logic [BW-1:0] a);
    exp_t x;
    x.nm = nm;
    x.v  = e;
    exp_q.push_back(x);
    act_q.push_back(a);
  endtask

  task automatic chk_bank(input string nm);
    logic [BW-1:0] e;
    for (int i = 0; i < N; i++) e[i*8 +: 8] = m_cfg[i];
    expect_v(nm, e, config_regs);
  endtask

  task automatic chk_miso(input string nm, input logic e);
    expect_v(nm, BW'(e), BW'(spi_miso));
  endtask

  task automatic cs_begin(input logic [1:0] m);
    mode     = m;
    cur_cpha = m[0];
    spi_clk  = m[1];
    repeat (4) @(negedge clk);
    spi_cs_n = 1'b0;
    half();
  endtask

  task automatic cs_end();
    half();
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int n,
                          output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i > 7 - n; i--) begin
      if (!cur_cpha) begin
        spi_mosi = mo[i];
        half();
        mi[i]   = spi_miso;
        spi_clk = ~spi_clk;
        half();
        spi_clk = ~spi_clk;
      end else begin
        spi_clk  = ~spi_clk;
        spi_mosi = mo[i];
        half();
        mi[i]   = spi_miso;
        spi_clk = ~spi_clk;
        half();
      end
    end
  endtask

  task automatic xfer(input logic [7:0] mo, input logic [7:0] e,
                      input bit chk, input string nm);
    logic [7:0] mi;
    spi_bits(mo, 8, mi);
    if (chk) expect_v(nm, BW'(e), BW'(mi));
  endtask

  initial begin
    status_regs       = '0;
    status_regs[7:0]  = 8'hCA;
    status_regs[15:8] = 8'h5A;
    for (int i = 0; i < N; i++) m_cfg[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk_bank("reset_cfg");
    chk_miso("reset_miso", 1'b0);
    rstb = 1'b1;
    repeat (3) @(negedge clk);

    // mode 0 write reg0
    cs_begin(2'b00);
    xfer(8'h80, 8'h00, 1'b1, "m0_cmd_miso");
    xfer(8'h3C, 8'h00, 1'b1, "m0_echo_miso");
    cs_end();
    m_cfg[0] = 8'h3C;
    chk_bank("m0_bank");

    // mode 3 status read
    cs_begin(2'b11);
    xfer(8'h40, 8'h00, 1'b1, "m3_cmd_miso");
    xfer(8'h00, 8'hCA, 1'b1, "m3_stat0");
    xfer(8'h00, AUTO ? 8'h5A : 8'hCA, 1'b1, "m3_stat_next");
    cs_end();
    chk_miso("m3_idle_miso", 1'b0);
    chk_bank("m3_bank");

    // mode 1 write at top address, second byte wraps or repeats
    cs_begin(2'b01);
    xfer(8'h8F, 8'h00, 1'b1, "m1_cmd_miso");
    xfer(8'h11, 8'h00, 1'b1, "m1_echo15");
    xfer(8'h22, 8'h3C, AUTO, "m1_echo0");
    cs_end();
    m_cfg[15] = AUTO ? 8'h11 : 8'h22;
    m_cfg[0]  = AUTO ? 8'h22 : 8'h3C;
    chk_bank("m1_bank");

    // abort after 5 data bits
    cs_begin(2'b00);
    xfer(8'h82, 8'h00, 1'b1, "ab_cmd_miso");
    spi_bits(8'hFF, 5, junk);
    cs_end();
    chk_bank("ab_bank");

    // mode 2 write then read back
    cs_begin(2'b10);
    xfer(8'h80, 8'h00, 1'b1, "m2_cmd_miso");
    xfer(8'hA5, AUTO ? 8'h22 : 8'h3C, 1'b1, "m2_echo0");
    cs_end();
    m_cfg[0] = 8'hA5;
    chk_bank("m2_bank");

    cs_begin(2'b10);
    xfer(8'h00, 8'h00, 1'b1, "m2r_cmd_miso");
    mode = 2'b11;
    xfer(8'h00, 8'hA5, 1'b1, "m2r_data");
    cs_end();
    chk_bank("m2r_bank");

    cs_begin(2'b10);
    xfer(8'h81, 8'h00, 1'b1, "m2w_cmd_miso");
    xfer(8'h01, 8'h00, 1'b1, "m2w_echo1");
    xfer(8'h02, 8'h00, AUTO, "m2w_echo2");
    cs_end();
    m_cfg[1] = AUTO ? 8'h01 : 8'h02;
    m_cfg[2] = AUTO ? 8'h02 : 8'h00;
    chk_bank("m2w_bank");

    // reset in the middle of a data byte
    cs_begin(2'b00);
    xfer(8'h40, 8'h00, 1'b1, "rs_cmd_miso");
    spi_bits(8'h00, 4, junk);
    repeat (2) @(negedge clk);
    chk_miso("rs_pre_miso", 1'b1);
    rstb = 1'b0;
    #2;
    for (int i = 0; i < N; i++) m_cfg[i] = 8'h00;
    chk_bank("rs_async_cfg");
    chk_miso("rs_async_miso", 1'b0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    half();
    spi_bits(8'h85, 8, junk);
    spi_bits(8'h66, 8, junk);
    half();
    chk_bank("rs_held_cfg");
    chk_miso("rs_held_miso", 1'b0);
    cs_end();

    cs_begin(2'b00);
    xfer(8'h85, 8'h00, 1'b1, "rs_new_cmd");
    xfer(8'h66, 8'h00, 1'b1, "rs_new_echo");
    cs_end();
    m_cfg[5] = 8'h66;
    chk_bank("rs_new_bank");

    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0",
               exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
